// File: rtl/md_unit.sv
// md_unit: execute-stage multiply/divide unit holding the architectural
// HI/LO registers.
//
// An accepted mult/div captures its result into pending_hi/pending_lo
// at the start edge. hi/lo are then written at the end of a fixed busy
// window of MULT_CYCLES or DIV_CYCLES cycles. MTHI/MTLO write hi/lo at
// the start edge and never raise busy.
//
// Optional feature: define MD_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU
// ops (op 6..9). These accumulate into {hi,lo} and use the MULT_CYCLES
// latency. Without the macro, op 6..9 are no-ops.
//
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-high reset
//   start  : one-cycle issue strobe, sampled only while busy=0
//   op     : 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO,
//            6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU, others no-op
//   rs_val : rs operand (dividend / multiplicand / MTHI-MTLO source)
//   rt_val : rt operand (divisor / multiplier)
//   busy   : registered, high while an operation is in flight
//   hi, lo : architectural HI/LO registers
//
// States:
//   IDLE | no operation in flight; start is accepted
//   BUSY | counting down; pending result is written to hi/lo at 1->0
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
`ifdef MD_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
    localparam logic [3:0] OP_MSUBU = 4'd9;
`endif

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    logic [0:0]  state;
    logic [3:0]  cnt;
    logic [31:0] pending_hi;
    logic [31:0] pending_lo;

    // Decoded operation class.
    logic        is_mul;
    logic        is_div;
    logic        is_acc;
    logic        is_sub;
    logic        mul_signed;
    logic        div_signed;

    always_comb begin
        is_mul     = 1'b0;
        is_div     = 1'b0;
        is_acc     = 1'b0;
        is_sub     = 1'b0;
        mul_signed = 1'b0;
        div_signed = 1'b0;
        case (op)
            OP_MULT:  begin is_mul = 1'b1; mul_signed = 1'b1; end
            OP_MULTU: is_mul = 1'b1;
            OP_DIV:   begin is_div = 1'b1; div_signed = 1'b1; end
            OP_DIVU:  is_div = 1'b1;
`ifdef MD_MADD_EN
            OP_MADD:  begin is_mul = 1'b1; is_acc = 1'b1; mul_signed = 1'b1; end
            OP_MADDU: begin is_mul = 1'b1; is_acc = 1'b1; end
            OP_MSUB:  begin is_mul = 1'b1; is_acc = 1'b1; is_sub = 1'b1; mul_signed = 1'b1; end
            OP_MSUBU: begin is_mul = 1'b1; is_acc = 1'b1; is_sub = 1'b1; end
`endif
            default:  ;
        endcase
    end

    // Multiply: the low 64 bits of the product of sign- or zero-extended
    // operands are the correct signed or unsigned 64-bit product.
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;
    logic [63:0] mul_result;

    assign mul_a   = {{32{mul_signed & rs_val[31]}}, rs_val};
    assign mul_b   = {{32{mul_signed & rt_val[31]}}, rt_val};
    assign product = mul_a * mul_b;

    always_comb begin
        mul_result = product;
        if (is_acc) begin
            mul_result = is_sub ? ({hi, lo} - product) : ({hi, lo} + product);
        end
    end

    // Divide on magnitudes so a single unsigned divider serves DIV and DIVU.
    // The 0x80000000 / -1 case falls out naturally: the magnitude
    // 0x80000000 negates back to 0x80000000 with a zero remainder.
    logic        div_by_zero;
    logic [31:0] div_a_mag;
    logic [31:0] div_b_mag;
    logic [31:0] div_b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quotient;
    logic [31:0] remainder;

    assign div_by_zero = (rt_val == 32'd0);
    assign div_a_mag   = (div_signed && rs_val[31]) ? (32'd0 - rs_val) : rs_val;
    assign div_b_mag   = (div_signed && rt_val[31]) ? (32'd0 - rt_val) : rt_val;
    assign div_b_safe  = div_by_zero ? 32'd1 : div_b_mag;
    assign q_mag       = div_a_mag / div_b_safe;
    assign r_mag       = div_a_mag % div_b_safe;
    assign quotient    = (div_signed && (rs_val[31] ^ rt_val[31])) ? (32'd0 - q_mag) : q_mag;
    assign remainder   = (div_signed && rs_val[31]) ? (32'd0 - r_mag) : r_mag;

    assign busy = (state == BUSY);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            pending_hi <= 32'd0;
            pending_lo <= 32'd0;
            hi         <= 32'd0;
            lo         <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_mul) begin
                            pending_hi <= mul_result[63:32];
                            pending_lo <= mul_result[31:0];
                            cnt        <= MULT_N;
                            state      <= BUSY;
                        end else if (is_div) begin
                            // A zero divisor replays the current hi/lo, so
                            // completion leaves them unchanged.
                            pending_hi <= div_by_zero ? hi : remainder;
                            pending_lo <= div_by_zero ? lo : quotient;
                            cnt        <= DIV_N;
                            state      <= BUSY;
                        end else if (op == OP_MTHI) begin
                            hi <= rs_val;
                        end else if (op == OP_MTLO) begin
                            lo <= rs_val;
                        end
                    end
                end
                default: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        hi    <= pending_hi;
                        lo    <= pending_lo;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors = 0;
    int miscompares = 0;

    // Reference model of HI/LO, and the scoreboard of expected results.
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [63:0] exp_q[$];

    md_unit #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    // Issue one op, check busy duration and that hi/lo hold during busy,
    // then pop the expected result and compare.
    task automatic run_op(input string name, input logic [3:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input int n_busy, input logic [63:0] exp);
        int cnt;
        logic [63:0] e;
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        start = 1'b0; op = 4'd15; rs_val = 32'h0; rt_val = 32'h0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            vectors++;
            if ({hi, lo} !== {m_hi, m_lo}) begin
                miscompares++;
                $display("FAIL %s hold: hi/lo=%h required %h", name, {hi, lo}, {m_hi, m_lo});
            end
            cnt++;
            @(posedge clk); #1;
        end
        vectors++;
        if (cnt !== n_busy) begin
            miscompares++;
            $display("FAIL %s busy_cycles: got %0d required %0d", name, cnt, n_busy);
        end
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s scoreboard: empty queue, got %h required entry", name, {hi, lo});
        end else begin
            e = exp_q.pop_front();
            if ({hi, lo} !== e) begin
                miscompares++;
                $display("FAIL %s result: hi/lo=%h required %h", name, {hi, lo}, e);
            end
            {m_hi, m_lo} = e;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 4'd0; rs_val = 32'h0; rt_val = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({busy, hi, lo} !== 65'd0) begin
            miscompares++;
            $display("FAIL reset: busy/hi/lo=%h required 0", {busy, hi, lo});
        end
        @(negedge clk);
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
    endtask

    task automatic test_mult();
        run_op("mult_neg", 4'd0, 32'hFFFFFFFE, 32'd3, MULT_CYCLES, 64'hFFFFFFFF_FFFFFFFA);
        run_op("multu_max", 4'd1, 32'hFFFFFFFF, 32'd2, MULT_CYCLES, 64'h00000001_FFFFFFFE);
        run_op("mult_negneg", 4'd0, 32'h80000000, 32'h80000000, MULT_CYCLES, 64'h40000000_00000000);
    endtask

    task automatic test_multu_random();
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
        for (int i = 0; i < 3; i++) begin
            a = $urandom;
            b = $urandom;
            p = 64'(a) * 64'(b);
            run_op("multu_rand", 4'd1, a, b, MULT_CYCLES, p);
        end
    endtask

    task automatic test_div();
        run_op("div_neg", 4'd2, 32'hFFFFFFF9, 32'd2, DIV_CYCLES, {32'hFFFFFFFF, 32'hFFFFFFFD});
        run_op("divu_zero", 4'd3, 32'd7, 32'd0, DIV_CYCLES, {m_hi, m_lo});
        run_op("div_ovf", 4'd2, 32'h80000000, 32'hFFFFFFFF, DIV_CYCLES, {32'h0, 32'h80000000});
        run_op("divu_big", 4'd3, 32'hFFFFFFFF, 32'd16, DIV_CYCLES, {32'h0000000F, 32'h0FFFFFFF});
        run_op("div_negdiv", 4'd2, 32'd7, 32'hFFFFFFFE, DIV_CYCLES, {32'h00000001, 32'hFFFFFFFD});
    endtask

    task automatic test_mthi_mtlo();
        run_op("mthi", 4'd4, 32'h12345678, 32'h0, 0, {32'h12345678, m_lo});
        run_op("mtlo", 4'd5, 32'hCAFEF00D, 32'h0, 0, {m_hi, 32'hCAFEF00D});
        run_op("noop15", 4'd15, 32'hDEADBEEF, 32'd3, 0, {m_hi, m_lo});
    endtask

    // MTLO and MTHI pulsed mid-DIV must not touch lo/hi or the busy window.
    task automatic test_start_while_busy();
        int cnt;
        logic [63:0] e;
        @(negedge clk);
        start = 1'b1; op = 4'd2; rs_val = 32'd100; rt_val = 32'd7;
        exp_q.push_back({32'd2, 32'd14});
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            if (cnt == 3 || cnt == 6) begin
                start = 1'b1; op = (cnt == 3) ? 4'd5 : 4'd4; rs_val = 32'hA5A5A5A5;
            end else begin
                start = 1'b0;
            end
            vectors++;
            if ({hi, lo} !== {m_hi, m_lo}) begin
                miscompares++;
                $display("FAIL busy_ignore hold: hi/lo=%h required %h", {hi, lo}, {m_hi, m_lo});
            end
            cnt++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        vectors++;
        if (cnt !== DIV_CYCLES) begin
            miscompares++;
            $display("FAIL busy_ignore busy_cycles: got %0d required %0d", cnt, DIV_CYCLES);
        end
        e = exp_q.pop_front();
        vectors++;
        if ({hi, lo} !== e) begin
            miscompares++;
            $display("FAIL busy_ignore result: hi/lo=%h required %h", {hi, lo}, e);
        end
        {m_hi, m_lo} = e;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; op = 4'd3; rs_val = 32'd1000; rt_val = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid pre: busy=%b required 1", busy);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({busy, hi, lo} !== 65'd0) begin
            miscompares++;
            $display("FAIL reset_mid: busy/hi/lo=%h required 0", {busy, hi, lo});
        end
        @(negedge clk);
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            vectors++;
            if ({busy, hi, lo} !== 65'd0) begin
                miscompares++;
                $display("FAIL reset_mid late: busy/hi/lo=%h required 0", {busy, hi, lo});
            end
        end
    endtask

    task automatic test_madd();
        run_op("mthi0", 4'd4, 32'h0, 32'h0, 0, {32'h0, m_lo});
        run_op("mtlo_ff", 4'd5, 32'hFFFFFFFF, 32'h0, 0, {32'h0, 32'hFFFFFFFF});
`ifdef MD_MADD_EN
        run_op("maddu", 4'd7, 32'd1, 32'd1, MULT_CYCLES, 64'h00000001_00000000);
        run_op("msubu", 4'd9, 32'd1, 32'd2, MULT_CYCLES, 64'h00000000_FFFFFFFE);
        run_op("madd_neg", 4'd6, 32'hFFFFFFFF, 32'd3, MULT_CYCLES, 64'h00000000_FFFFFFFB);
        run_op("msub_wrap", 4'd8, 32'h7FFFFFFF, 32'h7FFFFFFF, MULT_CYCLES,
               64'h00000000_FFFFFFFB - 64'h3FFFFFFF_00000001);
`else
        run_op("op6_noop", 4'd6, 32'd1, 32'd1, 0, {m_hi, m_lo});
        run_op("op9_noop", 4'd9, 32'd1, 32'd1, 0, {m_hi, m_lo});
`endif
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu_random();
        test_div();
        test_mthi_mtlo();
        test_start_while_busy();
        test_reset_mid();
        test_madd();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got no summary required one");
        $fatal(1);
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Execute-stage multiply/divide unit with architectural HI/LO registers.
- Sits beside the ALU between the E and M pipeline registers. Its HI/LO values are selected by the E stage for mfhi/mflo and forwarded as MDout into the M-stage register.
- Models multi-cycle latency with a busy counter. The hazard unit stalls D while an MD instruction is in flight.

Parameters:
- MULT_CYCLES, 5, number of busy cycles for mult/multu (and madd/msub family); range 1..15
- DIV_CYCLES, 10, number of busy cycles for div/divu; range 1..15

Ports:
- clk  in  1  clock, rising-edge
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle issue strobe from the E stage; sampled only when busy=0
- op  in  4  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU; others = no-op
- rs_val  in  32  forwarded rs operand
- rt_val  in  32  forwarded rt operand
- busy  out  1  registered; high while an operation is in flight
- hi  out  32  architectural HI
- lo  out  32  architectural LO

Behaviour:
- Reset is synchronous, active-high, on clock clk. At reset: busy=0, hi=0, lo=0, counter=0, pending result discarded. Reset mid-operation aborts the operation; its result is never written.
- States:
  - IDLE (busy=0).
  - BUSY (busy=1), with a 4-bit down-counter and pending_hi/pending_lo registers.
- IDLE with start=1 and op in {0..3, 6..9} (6..9 only when the feature is enabled):
  - Result is computed from rs_val/rt_val at the start edge and captured into pending_hi/pending_lo.
  - Counter loads N = MULT_CYCLES or DIV_CYCLES; go to BUSY.
  - busy is high for exactly N cycles after the start edge.
- BUSY: counter decrements each edge. At the edge where the counter goes 1->0:
  - hi<=pending_hi, lo<=pending_lo, busy<=0.
  - The new values are visible in the cycle busy first reads 0.
- hi/lo hold their old values throughout BUSY.
- MTHI/MTLO in IDLE: hi (or lo) <= rs_val at the start edge. busy stays 0 (zero latency).
- start while busy=1: ignored entirely, including MTHI/MTLO. The hazard unit guarantees this never happens; the bench checks that it is ignored.
- MULT: signed 32x32 -> 64-bit product; hi = [63:32], lo = [31:0]. MULTU: same, unsigned.
- DIV (signed):
  - lo = quotient, truncated toward zero; hi = remainder, with the sign of the dividend (rs).
  - 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (rt_val=0): busy still asserts for DIV_CYCLES; hi/lo are left unchanged at completion.
- Unknown op with start=1: no state change, busy stays 0.
- No other state. Output hi/lo come directly from registers; no combinational path from inputs to outputs.

Optional Feature:
- Macro: MD_MADD_EN.
- Defined:
  - ops 6..9 are legal, with MULT_CYCLES latency.
  - MADD/MADDU: {hi,lo} <= {hi,lo} + signed/unsigned product.
  - MSUB/MSUBU: {hi,lo} <= {hi,lo} - product, 64-bit wrap-around.
  - The accumulator operand is {hi,lo} sampled at the start edge.
- Not defined: ops 6..9 are treated as unknown (no-op, busy stays 0).

Test Plan:
- Reset, then MULT rs=0xFFFFFFFE (-2), rt=3 -> busy high for 5 cycles, hi/lo unchanged during busy; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU rs=0xFFFFFFFF, rt=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> 10 busy cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=7, rt=0 -> 10 busy cycles, hi/lo keep prior values.
- MTHI rs=0x12345678 in IDLE -> hi=0x12345678 the next cycle, busy never asserts. Start with MTLO during a DIV busy -> lo not written.
- Start DIV, assert reset at busy cycle 4 -> next cycle busy=0, hi=lo=0; no late writeback after 10 cycles.
- With MD_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU rs=1, rt=1 -> hi=1, lo=0 after 5 cycles. Without MD_MADD_EN: op=6 -> busy stays 0, hi/lo unchanged.
